// File: rtl/fft_fxp_pkg.sv
// Shared fixed-point definitions for the FFT datapath requantisers.
//   rnd_mode_t : run-time rounding selector carried with each sample
//   NUM_LANES  : complex sample lanes (0 = re, 1 = im)
//   DEF_CNT_W  : default width of the saturation event counter
package fft_fxp_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'b00,  // floor
    RND_HALF_UP   = 2'b01,  // ties toward +inf
    RND_CONV      = 2'b10,  // ties to even
    RND_TRUNC_ALT = 2'b11   // reserved code, behaves as floor
  } rnd_mode_t;

  localparam int NUM_LANES = 2;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/s_rnd_sat_lane.sv
// One lane of the requantiser, purely combinational, split in two halves
// so the top level can place a register between them.
//   Round half    : din (WIN, signed) + mode -> rnd (WIN-FRAC_DROP+1, signed)
//   Saturate half : sat_in (WIN-FRAC_DROP+1) -> dout (WOUT, signed), sat flag
// Requires WOUT <= WIN-FRAC_DROP.
module s_rnd_sat_lane
  import fft_fxp_pkg::*;
#(
  parameter int WIN       = 14,
  parameter int WOUT      = 12,
  parameter int FRAC_DROP = 1,
  localparam int RW       = WIN - FRAC_DROP + 1
) (
  input  logic [WIN-1:0]  din,
  input  logic [1:0]      mode,
  output logic [RW-1:0]   rnd,
  input  logic [RW-1:0]   sat_in,
  output logic [WOUT-1:0] dout,
  output logic            sat
);

  // Round half: one extra MSB keeps the carry of +1 on the max value.
  generate
    if (FRAC_DROP == 0) begin : g_no_rnd
      logic [1:0] unused_mode;
      assign unused_mode = mode;
      assign rnd = {din[WIN-1], din};
    end else begin : g_rnd
      localparam logic [FRAC_DROP-1:0] HALF = FRAC_DROP'(1) << (FRAC_DROP - 1);
      logic [WIN-FRAC_DROP-1:0] k;
      logic [FRAC_DROP-1:0]     r;
      logic                     inc;

      assign k = din[WIN-1:FRAC_DROP];  // arithmetic shift == drop LSBs
      assign r = din[FRAC_DROP-1:0];

      always_comb begin
        inc = 1'b0;
        case (rnd_mode_t'(mode))
          RND_HALF_UP: inc = (r >= HALF);
          RND_CONV:    inc = (r > HALF) || ((r == HALF) && k[0]);
          default:     inc = 1'b0;
        endcase
      end

      assign rnd = {k[WIN-FRAC_DROP-1], k} + RW'(inc);
    end
  endgenerate

  // Saturate half: the value fits in WOUT bits iff all bits from the
  // output sign position upward agree.
  logic [RW-WOUT:0] hi;
  logic             pos_ovf, neg_ovf;

  assign hi      = sat_in[RW-1:WOUT-1];
  assign pos_ovf = !sat_in[RW-1] && (|hi);
  assign neg_ovf =  sat_in[RW-1] && !(&hi);
  assign sat     = pos_ovf || neg_ovf;

  always_comb begin
    dout = sat_in[WOUT-1:0];
    if (pos_ovf) dout = {1'b0, {(WOUT-1){1'b1}}};
    if (neg_ovf) dout = {1'b1, {(WOUT-1){1'b0}}};
  end

endmodule

// File: rtl/s_rnd_sat_pipe.sv
// Two-stage pipelined requantiser for complex FFT samples.
//   S1 registers the rounded value (mode is applied at acceptance, so it is
//   bound to its sample), S2 registers the saturated result and flags.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   rnd_mode              : 00 floor, 01 half-up, 10 convergent, 11 floor
//   in_valid/in_ready     : input handshake, in_re/in_im WIN-bit signed
//   out_valid/out_ready   : output handshake, out_re/out_im WOUT-bit signed
//   out_sat               : {im,re} saturation flags of the output sample
//   stats_clr             : clears sat_cnt / sat_sticky
//   sat_cnt, sat_sticky   : saturation statistics
// Build option: define SAT_STATS_EN to enable the statistics logic;
// otherwise sat_cnt/sat_sticky are constant 0 and stats_clr is ignored.
module s_rnd_sat_pipe
  import fft_fxp_pkg::*;
#(
  parameter int WIN       = 14,
  parameter int WOUT      = 12,
  parameter int FRAC_DROP = 1,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       rnd_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIN-1:0]   in_re,
  input  logic [WIN-1:0]   in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WOUT-1:0]  out_re,
  output logic [WOUT-1:0]  out_im,
  output logic [1:0]       out_sat,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] sat_cnt,
  output logic             sat_sticky
);

  localparam int RW = WIN - FRAC_DROP + 1;

  logic [NUM_LANES-1:0][WIN-1:0]  lane_in;
  logic [NUM_LANES-1:0][RW-1:0]   lane_rnd;
  logic [NUM_LANES-1:0][WOUT-1:0] lane_out;
  logic [NUM_LANES-1:0]           lane_sat;

  logic                           s1_vld_q, s1_vld_d;
  logic [NUM_LANES-1:0][RW-1:0]   s1_dat_q, s1_dat_d;
  logic                           s2_vld_q, s2_vld_d;
  logic [NUM_LANES-1:0][WOUT-1:0] s2_dat_q, s2_dat_d;
  logic [NUM_LANES-1:0]           s2_sat_q, s2_sat_d;
  logic                           s1_en, s2_en;

  assign lane_in = {in_im, in_re};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    s_rnd_sat_lane #(
      .WIN       (WIN),
      .WOUT      (WOUT),
      .FRAC_DROP (FRAC_DROP)
    ) u_lane (
      .din    (lane_in[g]),
      .mode   (rnd_mode),
      .rnd    (lane_rnd[g]),
      .sat_in (s1_dat_q[g]),
      .dout   (lane_out[g]),
      .sat    (lane_sat[g])
    );
  end

  // A stage may load when empty or when the stage after it moves.
  always_comb begin
    s2_en    = !s2_vld_q || out_ready;
    s1_en    = !s1_vld_q || s2_en;
    in_ready = s1_en;

    s1_vld_d = s1_vld_q;
    s1_dat_d = s1_dat_q;
    s2_vld_d = s2_vld_q;
    s2_dat_d = s2_dat_q;
    s2_sat_d = s2_sat_q;

    if (s1_en) begin
      s1_vld_d = in_valid;
      if (in_valid) s1_dat_d = lane_rnd;
    end
    if (s2_en) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_dat_d = lane_out;
        s2_sat_d = lane_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
      s2_vld_q <= 1'b0;
      s2_dat_q <= '0;
      s2_sat_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_dat_q <= s1_dat_d;
      s2_vld_q <= s2_vld_d;
      s2_dat_q <= s2_dat_d;
      s2_sat_q <= s2_sat_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign out_re    = s2_dat_q[0];
  assign out_im    = s2_dat_q[1];
  assign out_sat   = s2_sat_q;

`ifdef SAT_STATS_EN
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;
  logic             sat_sticky_q, sat_sticky_d;
  logic             sat_evt;

  // Event is counted at the output transfer, once per sample.
  assign sat_evt = out_valid && out_ready && (|out_sat);

  always_comb begin
    sat_cnt_d    = sat_cnt_q;
    sat_sticky_d = sat_sticky_q;
    if (stats_clr) begin
      sat_cnt_d    = '0;
      sat_sticky_d = 1'b0;
    end else if (sat_evt) begin
      sat_sticky_d = 1'b1;
      if (sat_cnt_q != {CNT_W{1'b1}}) sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_q    <= '0;
      sat_sticky_q <= 1'b0;
    end else begin
      sat_cnt_q    <= sat_cnt_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign sat_cnt    = sat_cnt_q;
  assign sat_sticky = sat_sticky_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign sat_cnt          = '0;
  assign sat_sticky       = 1'b0;
`endif

endmodule

// File: tb/tb_s_rnd_sat_pipe.sv
module tb_s_rnd_sat_pipe;
  localparam int WIN = 14, WOUT = 12, FD = 1, CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       rnd_mode;
  logic             in_valid, in_ready;
  logic [WIN-1:0]   in_re, in_im;
  logic             out_valid, out_ready;
  logic [WOUT-1:0]  out_re, out_im;
  logic [1:0]       out_sat;
  logic             stats_clr;
  logic [CNT_W-1:0] sat_cnt;
  logic             sat_sticky;

  s_rnd_sat_pipe #(.WIN(WIN), .WOUT(WOUT), .FRAC_DROP(FD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rnd_mode(rnd_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_sat(out_sat), .stats_clr(stats_clr), .sat_cnt(sat_cnt), .sat_sticky(sat_sticky)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int s_re[$], s_im[$], s_md[$];
  int e_re[$], e_im[$], e_sat[$];
  int n_out;
  bit saw_stall;

  // Reference: floor-divide by 2^FD, apply rounding rule, clamp to WOUT range.
  function automatic int model(input int x, input int md, output bit sat);
    int d, k, r, h, v, mx, mn;
    d = 1 << FD;
    k = (x >= 0) ? x / d : -((-x + d - 1) / d);
    r = x - k * d;
    h = d / 2;
    v = k;
    if (FD > 0) begin
      if (md == 1 && r >= h) v = v + 1;
      if (md == 2 && (r > h || (r == h && (k % 2) != 0))) v = v + 1;
    end
    mx = (1 << (WOUT - 1)) - 1;
    mn = -(1 << (WOUT - 1));
    sat = 1'b0;
    if (v > mx) begin v = mx; sat = 1'b1; end
    if (v < mn) begin v = mn; sat = 1'b1; end
    return v;
  endfunction

  task automatic add(input int re, input int im, input int md);
    s_re.push_back(re); s_im.push_back(im); s_md.push_back(md);
  endtask

  task automatic expect_out(input int re, input int im, input int sat);
    e_re.push_back(re); e_im.push_back(im); e_sat.push_back(sat);
  endtask

  // Drives s_* through the DUT and scores every output transfer in order.
  // rdy_mode: 0 always ready, 1 random, 2 low on cycles 3..5.
  task automatic run_stream(input string tag, input int rdy_mode, input bit use_model);
    int idx, cyc, n_in, budget, gr, gi, gs;
    bit sr, si;
    idx = 0; cyc = 0; n_in = s_re.size(); budget = n_in * 8 + 50;
    n_out = 0; saw_stall = 0;
    while ((idx < n_in || e_re.size() > 0) && cyc < budget) begin
      out_ready = (rdy_mode == 0) ? 1'b1 :
                  (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : !(cyc >= 3 && cyc <= 5);
      in_valid = (idx < n_in);
      if (idx < n_in) begin
        in_re = s_re[idx][WIN-1:0];
        in_im = s_im[idx][WIN-1:0];
        rnd_mode = s_md[idx][1:0];
      end
      #1;
      if (in_valid && !in_ready) saw_stall = 1;
      if (out_valid && out_ready) begin
        checks++;
        if (e_re.size() == 0) begin
          failures++;
          $display("FAIL %s extra_output: got re=%0d, none required", tag, $signed(out_re));
        end else begin
          gr = int'($signed(out_re)); gi = int'($signed(out_im)); gs = int'(out_sat);
          if (gr !== e_re[0] || gi !== e_im[0] || gs !== e_sat[0]) begin
            failures++;
            $display("FAIL %s sample%0d: got re=%0d im=%0d sat=%0d, required re=%0d im=%0d sat=%0d",
                     tag, n_out, gr, gi, gs, e_re[0], e_im[0], e_sat[0]);
          end
          void'(e_re.pop_front()); void'(e_im.pop_front()); void'(e_sat.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        if (use_model) begin
          gr = model(s_re[idx], s_md[idx], sr);
          gi = model(s_im[idx], s_md[idx], si);
          expect_out(gr, gi, {30'd0, si, sr});
        end
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (idx != n_in || e_re.size() != 0) begin
      failures++;
      $display("FAIL %s timeout: accepted %0d of %0d, %0d outputs missing", tag, idx, n_in, e_re.size());
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL %s idle_out_valid: got %b, required 0", tag, out_valid);
      end
      @(posedge clk); #1;
    end
    s_re.delete(); s_im.delete(); s_md.delete();
    e_re.delete(); e_im.delete(); e_sat.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    do_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    checks++; if (out_re !== '0 || out_im !== '0) begin failures++; $display("FAIL reset_data: got re=%0d im=%0d, required 0", out_re, out_im); end
    checks++; if (out_sat !== 2'b00) begin failures++; $display("FAIL reset_sat: got %b, required 00", out_sat); end
    checks++; if (sat_cnt !== '0 || sat_sticky !== 1'b0) begin failures++; $display("FAIL reset_stats: got cnt=%0d sticky=%b, required 0", sat_cnt, sat_sticky); end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  task automatic test_sat_bounds();
    add( 4094, 0, 0);     expect_out( 2047, 0, 0);
    add( 4096, 0, 0);     expect_out( 2047, 0, 1);
    add(-4096, 0, 0);     expect_out(-2048, 0, 0);
    add(-4098, 0, 0);     expect_out(-2048, 0, 1);
    add(0, -4098, 0);     expect_out(0, -2048, 2);
    add(8191, -8192, 3);  expect_out(2047, -2048, 3);
    run_stream("sat_bounds", 0, 0);
  endtask

  task automatic test_round_ties();
    add( 5,  5, 0); expect_out( 2,  2, 0);
    add( 5,  5, 1); expect_out( 3,  3, 0);
    add( 5,  5, 2); expect_out( 2,  2, 0);
    add( 7,  7, 2); expect_out( 4,  4, 0);
    add(-5, -5, 0); expect_out(-3, -3, 0);
    add(-5, -5, 1); expect_out(-2, -2, 0);
    add(-5, -5, 2); expect_out(-2, -2, 0);
    add( 5, -5, 3); expect_out( 2, -3, 0);
    run_stream("round_ties", 0, 0);
  endtask

  task automatic test_carry();
    add(4095, 4095, 1); expect_out(2047, 2047, 3);
    add(4095, 0, 0);    expect_out(2047, 0, 0);
    add(4095, 4095, 2); expect_out(2047, 2047, 3);
    run_stream("carry", 0, 0);
  endtask

  task automatic test_random();
    logic [WIN-1:0] a, b;
    for (int i = 0; i < 300; i++) begin
      a = WIN'($urandom); b = WIN'($urandom);
      add(int'($signed(a)), int'($signed(b)), $urandom_range(0, 3));
    end
    run_stream("random", 1, 1);
  endtask

  task automatic test_backpressure();
    logic [WIN-1:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = WIN'($urandom); b = WIN'($urandom);
      add(int'($signed(a)), int'($signed(b)), $urandom_range(0, 2));
    end
    run_stream("backpressure", 2, 1);
    checks++; if (n_out != 8) begin failures++; $display("FAIL bp_count: got %0d outputs, required 8", n_out); end
    checks++; if (saw_stall !== 1'b1) begin failures++; $display("FAIL bp_in_ready_drop: got %b, required 1", saw_stall); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_re = 14'd100; in_im = 14'd50; rnd_mode = 2'b00;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    #1;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL mid_full: got out_valid=%b in_ready=%b, required 1 0", out_valid, in_ready); end
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid: got %b, required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready: got %b, required 1", in_ready); end
    out_ready = 1'b1; in_valid = 1'b1; in_re = 14'd9; in_im = -14'sd9; rnd_mode = 2'b01;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_lat1: got out_valid=%b, required 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || $signed(out_re) !== 12'sd5 || $signed(out_im) !== -12'sd4) begin
      failures++;
      $display("FAIL mid_lat2: got valid=%b re=%0d im=%0d, required 1 5 -4", out_valid, $signed(out_re), $signed(out_im));
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_no_dup: got out_valid=%b, required 0", out_valid); end
  endtask

  task automatic test_stats();
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) add(4096, 0, 0);
    run_stream("stats_3", 0, 1);
`ifdef SAT_STATS_EN
    checks++; if (sat_cnt !== 4'd3) begin failures++; $display("FAIL stats_cnt3: got %0d, required 3", sat_cnt); end
    checks++; if (sat_sticky !== 1'b1) begin failures++; $display("FAIL stats_sticky: got %b, required 1", sat_sticky); end
    stats_clr = 1'b1; @(posedge clk); #1; stats_clr = 1'b0;
    checks++; if (sat_cnt !== 4'd0 || sat_sticky !== 1'b0) begin failures++; $display("FAIL stats_clr: got cnt=%0d sticky=%b, required 0 0", sat_cnt, sat_sticky); end
    for (int i = 0; i < 20; i++) add(0, -8000, $urandom_range(0, 3));
    run_stream("stats_20", 1, 1);
    checks++; if (sat_cnt !== 4'd15) begin failures++; $display("FAIL stats_cnt_hold: got %0d, required 15", sat_cnt); end
    checks++; if (sat_sticky !== 1'b1) begin failures++; $display("FAIL stats_sticky2: got %b, required 1", sat_sticky); end
`else
    checks++; if (sat_cnt !== 4'd0 || sat_sticky !== 1'b0) begin failures++; $display("FAIL stats_tied: got cnt=%0d sticky=%b, required 0 0", sat_cnt, sat_sticky); end
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; stats_clr = 1'b0;
    rnd_mode = 2'b00; in_re = '0; in_im = '0;
    test_reset();
    test_sat_bounds();
    test_round_ties();
    test_carry();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
